// File: rtl/matmul_seq_mac.sv
// Sequential matrix multiplier, C = A x B (or C += A x B), using one shared MAC.
// Define MATMUL_SAT_EN to clamp results to the OW range and report overflow on ovf.
module matmul_seq_mac #(
    parameter int EW    = 8,
    parameter int ROW   = 4,
    parameter int INNER = 4,
    parameter int COL   = 4,
    parameter int OW    = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    mode_signed,
    input  logic                    accumulate,
    input  logic [EW*ROW*INNER-1:0] in_A,
    input  logic [EW*INNER*COL-1:0] in_B,
    output logic [OW*ROW*COL-1:0]   out_M,
    output logic                    busy,
    output logic                    done,
    output logic                    ovf
);

    localparam int PW = 2 * EW + $clog2(INNER);
    localparam int AW = ((OW > PW) ? OW : PW) + 2;
    localparam int RW = (ROW > 1) ? $clog2(ROW) : 1;
    localparam int CW = (COL > 1) ? $clog2(COL) : 1;
    localparam int KW = (INNER > 1) ? $clog2(INNER) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MAC,
        S_DONE
    } state_e;

    state_e                    state_q, state_d;
    logic [RW-1:0]             r_q, r_d;
    logic [CW-1:0]             c_q, c_d;
    logic [KW-1:0]             k_q, k_d;
    logic [EW*ROW*INNER-1:0]   a_q, a_d;
    logic [EW*INNER*COL-1:0]   b_q, b_d;
    logic                      sgn_q, sgn_d;
    logic                      acc_q, acc_d;
    logic signed [AW-1:0]      sum_q, sum_d;
    logic [OW*ROW*COL-1:0]     out_q, out_d;

    int                        a_idx, b_idx, o_idx;
    logic [EW-1:0]             a_el, b_el;
    logic [OW-1:0]             old_el;
    logic signed [EW:0]        a_x, b_x;
    logic signed [2*EW+1:0]    prod;
    logic signed [OW:0]        old_x;
    logic signed [AW-1:0]      prod_w, base, sum_new;
    logic [OW-1:0]             fin;
    logic                      k_last, c_last, r_last;

`ifdef MATMUL_SAT_EN
    logic                      ovf_q, ovf_d;
    logic                      clamp;
    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    assign out_M = out_q;
    assign busy  = (state_q == S_MAC);
    assign done  = (state_q == S_DONE);

    assign k_last = (k_q == KW'(INNER - 1));
    assign c_last = (c_q == CW'(COL - 1));
    assign r_last = (r_q == RW'(ROW - 1));

    // Operands widened by one bit so a single signed multiply covers both modes
    always_comb begin
        a_idx   = int'(r_q) * INNER + int'(k_q);
        b_idx   = int'(k_q) * COL + int'(c_q);
        o_idx   = int'(r_q) * COL + int'(c_q);
        a_el    = a_q[EW*a_idx +: EW];
        b_el    = b_q[EW*b_idx +: EW];
        old_el  = out_q[OW*o_idx +: OW];
        a_x     = {sgn_q & a_el[EW-1], a_el};
        b_x     = {sgn_q & b_el[EW-1], b_el};
        prod    = a_x * b_x;
        prod_w  = AW'(prod);
        old_x   = {sgn_q & old_el[OW-1], old_el};
        if (k_q != '0) begin
            base = sum_q;
        end else if (acc_q) begin
            base = AW'(old_x);
        end else begin
            base = '0;
        end
        sum_new = base + prod_w;
`ifdef MATMUL_SAT_EN
        if (sgn_q) begin
            clamp = !((&sum_new[AW-1:OW-1]) || !(|sum_new[AW-1:OW-1]));
            if (!clamp) begin
                fin = sum_new[OW-1:0];
            end else if (sum_new[AW-1]) begin
                fin = {1'b1, {(OW-1){1'b0}}};
            end else begin
                fin = {1'b0, {(OW-1){1'b1}}};
            end
        end else begin
            clamp = |sum_new[AW-1:OW];
            fin   = clamp ? {OW{1'b1}} : sum_new[OW-1:0];
        end
`else
        fin = sum_new[OW-1:0];
`endif
    end

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        c_d     = c_q;
        k_d     = k_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        out_d   = out_q;
`ifdef MATMUL_SAT_EN
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_MAC;
                    a_d     = in_A;
                    b_d     = in_B;
                    sgn_d   = mode_signed;
                    acc_d   = accumulate;
                    r_d     = '0;
                    c_d     = '0;
                    k_d     = '0;
                    sum_d   = '0;
`ifdef MATMUL_SAT_EN
                    ovf_d   = 1'b0;
`endif
                end
            end
            S_MAC: begin
                sum_d = sum_new;
                if (k_last) begin
                    out_d[OW*o_idx +: OW] = fin;
`ifdef MATMUL_SAT_EN
                    ovf_d = ovf_q | clamp;
`endif
                    k_d = '0;
                    if (c_last) begin
                        c_d = '0;
                        if (r_last) begin
                            state_d = S_DONE;
                        end else begin
                            r_d = r_q + RW'(1);
                        end
                    end else begin
                        c_d = c_q + CW'(1);
                    end
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            r_q     <= '0;
            c_q     <= '0;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            acc_q   <= 1'b0;
            sum_q   <= '0;
            out_q   <= '0;
`ifdef MATMUL_SAT_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            c_q     <= c_d;
            k_q     <= k_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            out_q   <= out_d;
`ifdef MATMUL_SAT_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

endmodule

// File: tb/tb_matmul_seq_mac.sv
// Self-checking bench for matmul_seq_mac: reference model plus directed values.
// Expected results follow MATMUL_SAT_EN when the bench is built with it.
module tb_matmul_seq_mac;

    localparam int EW = 8, ROW = 4, INNER = 4, COL = 4, OW = 16;
    localparam int N   = ROW * COL * INNER;
    localparam int AWD = EW * ROW * INNER;
    localparam int BWD = EW * INNER * COL;
    localparam int CWD = OW * ROW * COL;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic mode_signed = 1'b0;
    logic accumulate = 1'b0;
    logic [AWD-1:0] in_A = '0;
    logic [BWD-1:0] in_B = '0;
    logic [CWD-1:0] out_M;
    logic busy, done, ovf;

    logic ns_start = 1'b0;
    logic [23:0] ns_A = '0;
    logic [59:0] ns_B = '0;
    logic [119:0] ns_M;
    logic ns_busy, ns_done, ns_ovf;

    always #5 clk = ~clk;

    matmul_seq_mac #(.EW(EW), .ROW(ROW), .INNER(INNER), .COL(COL), .OW(OW)) dut (
        .clk(clk), .reset(reset), .start(start), .mode_signed(mode_signed),
        .accumulate(accumulate), .in_A(in_A), .in_B(in_B), .out_M(out_M),
        .busy(busy), .done(done), .ovf(ovf)
    );

    matmul_seq_mac #(.EW(4), .ROW(2), .INNER(3), .COL(5), .OW(12)) dut_ns (
        .clk(clk), .reset(reset), .start(ns_start), .mode_signed(1'b0),
        .accumulate(1'b0), .in_A(ns_A), .in_B(ns_B), .out_M(ns_M),
        .busy(ns_busy), .done(ns_done), .ovf(ns_ovf)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [CWD-1:0] got, input logic [CWD-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    function automatic longint sx(input logic [OW-1:0] v, input int w, input bit s);
        longint x;
        x = longint'(v);
        if (s && v[w-1]) x = x - (longint'(1) << w);
        return x;
    endfunction

    // Plain integer matrix product, then wrap or clamp to OW bits
    function automatic logic [CWD-1:0] mm(input logic [AWD-1:0] a, input logic [BWD-1:0] b,
                                          input bit s, input bit acc,
                                          input logic [CWD-1:0] old, output bit ov);
        logic [CWD-1:0] res;
        longint v;
`ifdef MATMUL_SAT_EN
        longint lo, hi;
`endif
        ov = 1'b0;
        res = '0;
        for (int r = 0; r < ROW; r++) begin
            for (int c = 0; c < COL; c++) begin
                v = acc ? sx(old[OW*(r*COL+c) +: OW], OW, s) : 0;
                for (int k = 0; k < INNER; k++) begin
                    v += sx(OW'(a[EW*(r*INNER+k) +: EW]), EW, s)
                       * sx(OW'(b[EW*(k*COL+c) +: EW]), EW, s);
                end
`ifdef MATMUL_SAT_EN
                lo = s ? -(longint'(1) << (OW - 1)) : 0;
                hi = s ? (longint'(1) << (OW - 1)) - 1 : (longint'(1) << OW) - 1;
                if (v > hi) begin
                    v = hi;
                    ov = 1'b1;
                end else if (v < lo) begin
                    v = lo;
                    ov = 1'b1;
                end
`endif
                res[OW*(r*COL+c) +: OW] = OW'(v);
            end
        end
        return res;
    endfunction

    int ph = 0;
    logic [CWD-1:0] exp_out = '0;
    logic [CWD-1:0] exp_next = '0;
    bit exp_ovf = 1'b0;
    bit ov_next = 1'b0;
    bit chk_en = 1'b0;

    // ph: 0 idle, 1..N computing, N+1 done cycle
    always @(posedge clk) begin
        if (reset) begin
            ph = 0;
            exp_out = '0;
            exp_ovf = 1'b0;
        end else if (ph == 0) begin
            if (start) begin
                exp_next = mm(in_A, in_B, mode_signed, accumulate, exp_out, ov_next);
                ph = 1;
            end
        end else if (ph < N) begin
            ph++;
        end else if (ph == N) begin
            ph = N + 1;
            exp_out = exp_next;
            exp_ovf = ov_next;
        end else begin
            ph = 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", CWD'(busy), CWD'(ph >= 1 && ph <= N));
            chk("done", CWD'(done), CWD'(ph == N + 1));
            if (ph == 0 || ph == N + 1) begin
                chk("out_M", out_M, exp_out);
                chk("ovf", CWD'(ovf), CWD'(exp_ovf));
            end
        end
    end

    task automatic run(input logic [AWD-1:0] a, input logic [BWD-1:0] b,
                       input bit s, input bit acc, input bit poke, output int bc);
        bit seen;
        bc = 0;
        seen = 1'b0;
        @(negedge clk);
        in_A = a;
        in_B = b;
        mode_signed = s;
        accumulate = acc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        in_A = {$urandom(), $urandom(), $urandom(), $urandom()};
        in_B = {$urandom(), $urandom(), $urandom(), $urandom()};
        mode_signed = ~s;
        accumulate = ~acc;
        for (int i = 0; i < N + 10 && !seen; i++) begin
            start = 1'b0;
            if (done) begin
                seen = 1'b1;
                if (poke) start = 1'b1;
            end else begin
                if (busy) bc++;
                if (poke && bc == 5) start = 1'b1;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("done_seen", CWD'(seen), CWD'(1));
    endtask

    logic [AWD-1:0] ra;
    logic [BWD-1:0] rb;
    int bc, dcnt, nbc;
    bit nseen;

    initial begin
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        chk("reset_out", out_M, '0);
        reset = 1'b0;

        run({16{8'h0a}}, {16{8'h0a}}, 1'b0, 1'b0, 1'b0, bc);
        chk("busy_cycles", CWD'(bc), CWD'(64));
        chk("c_0a", out_M, {16{16'h0190}});

        ra = 128'h100f0e0d0c0b0a090807060504030201;
        rb = 128'h0102030405060708090a0b0c0d0e0f10;
        run(ra, rb, 1'b0, 1'b0, 1'b0, bc);
        chk("c00_seq", CWD'(out_M[15:0]), CWD'(16'h0050));

        run({16{8'hff}}, {16{8'h02}}, 1'b1, 1'b0, 1'b0, bc);
        chk("signed_m8", out_M, {16{16'hfff8}});
        run({16{8'hff}}, {16{8'h02}}, 1'b0, 1'b0, 1'b0, bc);
        chk("unsigned_7f8", out_M, {16{16'h07f8}});

        run({16{8'h0a}}, {16{8'h0a}}, 1'b0, 1'b0, 1'b0, bc);
        run({16{8'h0a}}, {16{8'h0a}}, 1'b0, 1'b1, 1'b0, bc);
        chk("accum_320", out_M, {16{16'h0320}});

        run({16{8'hff}}, {16{8'hff}}, 1'b0, 1'b0, 1'b0, bc);
`ifdef MATMUL_SAT_EN
        chk("ovf_u", out_M, {16{16'hffff}});
        chk("ovf_u_flag", CWD'(ovf), CWD'(1));
`else
        chk("ovf_u", out_M, {16{16'hf804}});
        chk("ovf_u_flag", CWD'(ovf), CWD'(0));
`endif
        run({16{8'h80}}, {16{8'h80}}, 1'b1, 1'b0, 1'b0, bc);
`ifdef MATMUL_SAT_EN
        chk("ovf_s", out_M, {16{16'h7fff}});
        chk("ovf_s_flag", CWD'(ovf), CWD'(1));
`else
        chk("ovf_s", out_M, {16{16'h0000}});
        chk("ovf_s_flag", CWD'(ovf), CWD'(0));
`endif

        // Abort during MAC cycle 10
        @(negedge clk);
        in_A = {16{8'h0a}};
        in_B = {16{8'h0a}};
        mode_signed = 1'b0;
        accumulate = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", CWD'(busy), CWD'(0));
        chk("abort_out", out_M, '0);
        dcnt = 0;
        for (int i = 0; i < N + 5; i++) begin
            if (done) dcnt++;
            @(negedge clk);
        end
        chk("abort_no_done", CWD'(dcnt), CWD'(0));

        ra = {$urandom(), $urandom(), $urandom(), $urandom()};
        rb = {$urandom(), $urandom(), $urandom(), $urandom()};
        run(ra, rb, 1'b1, 1'b0, 1'b1, bc);
        chk("poke_busy", CWD'(bc), CWD'(64));
        repeat (3) @(negedge clk);

        for (int t = 0; t < 8; t++) begin
            ra = {$urandom(), $urandom(), $urandom(), $urandom()};
            rb = {$urandom(), $urandom(), $urandom(), $urandom()};
            run(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, bc);
            chk("rand_busy", CWD'(bc), CWD'(64));
        end

        @(negedge clk);
        ns_A = {6{4'h3}};
        ns_B = {15{4'h2}};
        ns_start = 1'b1;
        @(negedge clk);
        ns_start = 1'b0;
        nbc = 0;
        nseen = 1'b0;
        for (int i = 0; i < 60 && !nseen; i++) begin
            if (ns_done) nseen = 1'b1;
            else if (ns_busy) nbc++;
            @(negedge clk);
        end
        chk("ns_done", CWD'(nseen), CWD'(1));
        chk("ns_busy", CWD'(nbc), CWD'(30));
        chk("ns_out", CWD'(ns_M), CWD'({10{12'h012}}));
        chk("ns_ovf", CWD'(ns_ovf), CWD'(0));

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
